// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and defaults for the HI/LO result stage.
//   hilo_state_t  : pending-operation state of hilo_unit
//   HILO_DATA_W   : default width of HI, LO and data ports
//   HILO_TMO_CYC  : default watchdog limit in waiting cycles
//   HILO_CNT_W    : wait-counter width for the default watchdog limit
//   Optional feature macro: HILO_WATCHDOG_EN (see hilo_unit).
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MULT = 2'd1,
    WAIT_DIV  = 2'd2
  } hilo_state_t;

  localparam int HILO_DATA_W  = 32;
  localparam int HILO_TMO_CYC = 40;
  localparam int HILO_CNT_W   = $clog2(HILO_TMO_CYC + 1);

endpackage

// File: rtl/hilo_watchdog.sv
// hilo_watchdog: counts cycles spent waiting for a long operation and flags
// the cycle in which the wait limit is reached.
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-low
//   waiting in   hilo_unit is in a WAIT_* state
//   expire  out  combinational: this is the TIMEOUT_CYC-th waiting cycle
module hilo_watchdog
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYC = HILO_TMO_CYC,
  parameter int CNT_W       = HILO_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  output logic expire
);

  logic [CNT_W-1:0] cnt_p0;

  // Counter holds the number of completed waiting cycles; any idle cycle
  // returns it to zero so a new operation always starts from a clean count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_p0 <= '0;
    end else if (!waiting) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  assign expire = waiting && (cnt_p0 == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO architectural registers downstream of MULT and DIV.
// Captures the pending unit's result, services mthi/mtlo while idle, stalls
// mfhi/mflo while a result is pending and raises a one-cycle divide-by-zero
// exception pulse. With HILO_WATCHDOG_EN defined, a watchdog abandons a
// wait that exceeds TIMEOUT_CYC cycles and pulses timeout_exc; otherwise
// timeout_exc is tied low.
// Ports:
//   clock, reset (async active-low)
//   start_mult, start_div           : launch pulses from control
//   mult_done, mult_hi, mult_lo     : MULT result
//   div_done, div_hi, div_lo, div0  : DIV remainder/quotient, zero-divisor flag
//   mthi_we, mtlo_we, wdata         : mthi/mtlo writes
//   rd_req                          : mfhi/mflo in flight
//   hi_out, lo_out                  : HI/LO registers
//   busy, stall                     : pending flag, read stall (comb)
//   div0_exc, timeout_exc           : registered one-cycle exception pulses
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W      = HILO_DATA_W,
  parameter int TIMEOUT_CYC = HILO_TMO_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  input  logic              div0,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_req,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              stall,
  output logic              div0_exc,
  output logic              timeout_exc
);

  hilo_state_t       state_p0, state_nx;
  logic [DATA_W-1:0] hi_p0, hi_nx;
  logic [DATA_W-1:0] lo_p0, lo_nx;
  logic              div0_p0, div0_nx;
  logic              tmo_p0, tmo_nx;
  logic              expire;

`ifdef HILO_WATCHDOG_EN
  hilo_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       ($clog2(TIMEOUT_CYC + 1))
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .waiting (state_p0 != IDLE),
    .expire  (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // A done in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nx = state_p0;
    hi_nx    = hi_p0;
    lo_nx    = lo_p0;
    div0_nx  = 1'b0;
    tmo_nx   = 1'b0;
    case (state_p0)
      IDLE: begin
        if (mthi_we) hi_nx = wdata;
        if (mtlo_we) lo_nx = wdata;
        if (start_div)       state_nx = WAIT_DIV;
        else if (start_mult) state_nx = WAIT_MULT;
      end
      WAIT_MULT: begin
        if (mult_done) begin
          hi_nx    = mult_hi;
          lo_nx    = mult_lo;
          state_nx = IDLE;
        end else if (expire) begin
          tmo_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_DIV: begin
        if (div_done) begin
          if (div0) begin
            div0_nx = 1'b1;
          end else begin
            hi_nx = div_hi;
            lo_nx = div_lo;
          end
          state_nx = IDLE;
        end else if (expire) begin
          tmo_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- stage p0: architectural state and exception pulses ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      hi_p0    <= '0;
      lo_p0    <= '0;
      div0_p0  <= 1'b0;
      tmo_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      hi_p0    <= hi_nx;
      lo_p0    <= lo_nx;
      div0_p0  <= div0_nx;
      tmo_p0   <= tmo_nx;
    end
  end

  assign hi_out      = hi_p0;
  assign lo_out      = lo_p0;
  assign busy        = (state_p0 != IDLE);
  assign stall       = rd_req & busy;
  assign div0_exc    = div0_p0;
  assign timeout_exc = tmo_p0;

endmodule
